// File: rtl/ldreg_pkg.sv
// Shared types for the load-register bank.
// Latency: n/a (types only).
// Backpressure: n/a.
package ldreg_pkg;

  // LD_IMM applies a load at the edge it is requested.
  // LD_DEFER stages the load value until a global commit.
  typedef enum logic {
    LD_IMM   = 1'b0,
    LD_DEFER = 1'b1
  } ld_mode_e;

endpackage

// File: rtl/ldreg_ch.sv
// One channel: data register with load, optional staged load, and change flag.
// Latency: q updates 1 cycle after en/ld/commit; chg follows q by the same edge.
// Backpressure: none, every request is acted on at the next edge.
module ldreg_ch
  import ldreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter ld_mode_e         LD_MODE = LD_IMM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] lval_i,
  input  logic             commit_i,
  output logic [WIDTH-1:0] q_o,
  output logic             pend_o,
  output logic             chg_o,
  output logic             apply_o
);

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] q_nxt;
  logic             apply;
  logic             stage_wr;

  // Decide whether a load lands on q this edge, and from where.
  always_comb begin
    apply    = 1'b0;
    stage_wr = 1'b0;
    ld_val   = lval_i;
    if (LD_MODE == LD_IMM) begin
      apply = ld_i;
    end else begin
      if (ld_i && commit_i) begin
        // Load and commit together bypass the stage.
        apply = 1'b1;
      end else if (commit_i && pend_o) begin
        apply  = 1'b1;
        ld_val = stage_q;
      end else if (ld_i) begin
        stage_wr = 1'b1;
      end
    end
    q_nxt = apply ? ld_val : (en_i ? d_i : q_o);
  end

  assign apply_o = apply;

  // Data register and change flag; reset never flags a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o   <= RST_VAL;
      chg_o <= 1'b0;
    end else begin
      q_o   <= q_nxt;
      chg_o <= (q_nxt != q_o);
    end
  end

  // Stage register: last staged write wins, any commit retires the pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= RST_VAL;
      pend_o  <= 1'b0;
    end else if (stage_wr) begin
      stage_q <= lval_i;
      pend_o  <= 1'b1;
    end else if (commit_i) begin
      pend_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/ldreg_bank.sv
// Bank of NCH load registers plus a saturating count of applied loads.
// Latency: 1 cycle from request to q/pend/chg/ldcnt.
// Backpressure: none, all inputs are accepted every cycle.
module ldreg_bank
  import ldreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               NCH     = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter ld_mode_e         LD_MODE = LD_IMM,
  parameter int               CW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] d_i,
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH-1:0]       ld_i,
  input  logic [NCH*WIDTH-1:0] lval_i,
  input  logic                 commit_i,
  output logic [NCH*WIDTH-1:0] q_o,
  output logic [NCH-1:0]       pend_o,
  output logic [NCH-1:0]       chg_o,
  output logic [CW-1:0]        ldcnt_o
);

  // Wide enough for count plus a full-bank increment, so the compare never wraps.
  localparam int CNTW = $clog2(NCH + 1) + CW;
  localparam logic [CNTW-1:0] CNT_MAX = {{(CNTW - CW){1'b0}}, {CW{1'b1}}};

  logic [NCH-1:0]  apply;
  logic [CNTW-1:0] inc;
  logic [CNTW-1:0] sum;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ldreg_ch #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL),
      .LD_MODE(LD_MODE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .d_i     (d_i[c*WIDTH +: WIDTH]),
      .en_i    (en_i[c]),
      .ld_i    (ld_i[c]),
      .lval_i  (lval_i[c*WIDTH +: WIDTH]),
      .commit_i(commit_i),
      .q_o     (q_o[c*WIDTH +: WIDTH]),
      .pend_o  (pend_o[c]),
      .chg_o   (chg_o[c]),
      .apply_o (apply[c])
    );
  end

  // Number of channels whose load lands this edge, added to the current count.
  always_comb begin
    inc = '0;
    for (int c = 0; c < NCH; c++) begin
      inc = inc + CNTW'(apply[c]);
    end
    sum = CNTW'(ldcnt_o) + inc;
  end

  // Saturating load counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ldcnt_o <= '0;
    end else if (sum > CNT_MAX) begin
      ldcnt_o <= {CW{1'b1}};
    end else begin
      ldcnt_o <= sum[CW-1:0];
    end
  end

endmodule

// File: tb/tb_ldreg_bank.sv
// Drives three banks (immediate, deferred, immediate with 2-bit counter and nonzero reset
// value) from one shared stimulus and checks them against a per-rule reference model.
module tb_ldreg_bank;
  import ldreg_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] d, lval;
  logic [N-1:0]   en, ld;
  logic           commit;

  logic [N*W-1:0] q_a, q_b, q_c;
  logic [N-1:0]   pend_a, pend_b, pend_c;
  logic [N-1:0]   chg_a, chg_b, chg_c;
  logic [7:0]     cnt_a, cnt_b;
  logic [1:0]     cnt_c;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = immediate, 1 = deferred, 2 = immediate with 2-bit counter.
  int mq[3][N];
  int mst[3][N];
  int mpend[3][N];
  int mchg[3][N];
  int mcnt[3];
  int rv[3]    = '{0, 0, 'hC3};
  int defer[3] = '{0, 1, 0};
  int cap[3]   = '{255, 255, 3};

  always #5 clk = ~clk;

  ldreg_bank #(.WIDTH(W), .NCH(N), .RST_VAL(8'h00), .LD_MODE(LD_IMM), .CW(8)) u_a (
    .clk(clk), .rst(rst), .d_i(d), .en_i(en), .ld_i(ld), .lval_i(lval), .commit_i(commit),
    .q_o(q_a), .pend_o(pend_a), .chg_o(chg_a), .ldcnt_o(cnt_a));

  ldreg_bank #(.WIDTH(W), .NCH(N), .RST_VAL(8'h00), .LD_MODE(LD_DEFER), .CW(8)) u_b (
    .clk(clk), .rst(rst), .d_i(d), .en_i(en), .ld_i(ld), .lval_i(lval), .commit_i(commit),
    .q_o(q_b), .pend_o(pend_b), .chg_o(chg_b), .ldcnt_o(cnt_b));

  ldreg_bank #(.WIDTH(W), .NCH(N), .RST_VAL(8'hC3), .LD_MODE(LD_IMM), .CW(2)) u_c (
    .clk(clk), .rst(rst), .d_i(d), .en_i(en), .ld_i(ld), .lval_i(lval), .commit_i(commit),
    .q_o(q_c), .pend_o(pend_c), .chg_o(chg_c), .ldcnt_o(cnt_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one clock edge using the current inputs.
  task automatic model_edge();
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        for (int c = 0; c < N; c++) begin
          mq[m][c] = rv[m]; mst[m][c] = rv[m]; mpend[m][c] = 0; mchg[m][c] = 0;
        end
        mcnt[m] = 0;
      end else begin
        int loads = 0;
        for (int c = 0; c < N; c++) begin
          int lv = int'(lval[c*W +: W]);
          int dv = int'(d[c*W +: W]);
          int nq = mq[m][c];
          if (defer[m] == 0) begin
            if (ld[c]) begin nq = lv; loads++; end
            else if (en[c]) nq = dv;
          end else if (ld[c] && commit) begin
            nq = lv; mpend[m][c] = 0; loads++;
          end else if (commit && mpend[m][c] != 0) begin
            nq = mst[m][c]; mpend[m][c] = 0; loads++;
          end else begin
            if (ld[c]) begin mst[m][c] = lv; mpend[m][c] = 1; end
            if (en[c]) nq = dv;
          end
          mchg[m][c] = (nq != mq[m][c]) ? 1 : 0;
          mq[m][c] = nq;
        end
        mcnt[m] = (mcnt[m] + loads > cap[m]) ? cap[m] : mcnt[m] + loads;
      end
    end
  endtask

  function automatic logic [31:0] exp_q(input int m);
    logic [31:0] v = '0;
    for (int c = 0; c < N; c++) v[c*W +: W] = mq[m][c][W-1:0];
    return v;
  endfunction

  function automatic logic [31:0] exp_pend(input int m);
    logic [31:0] v = '0;
    for (int c = 0; c < N; c++) v[c] = (mpend[m][c] != 0);
    return v;
  endfunction

  function automatic logic [31:0] exp_chg(input int m);
    logic [31:0] v = '0;
    for (int c = 0; c < N; c++) v[c] = (mchg[m][c] != 0);
    return v;
  endfunction

  task automatic compare_all();
    check("imm_q",     32'(q_a),    exp_q(0));
    check("imm_pend",  32'(pend_a), exp_pend(0));
    check("imm_chg",   32'(chg_a),  exp_chg(0));
    check("imm_cnt",   32'(cnt_a),  32'(mcnt[0]));
    check("def_q",     32'(q_b),    exp_q(1));
    check("def_pend",  32'(pend_b), exp_pend(1));
    check("def_chg",   32'(chg_b),  exp_chg(1));
    check("def_cnt",   32'(cnt_b),  32'(mcnt[1]));
    check("sat_q",     32'(q_c),    exp_q(2));
    check("sat_pend",  32'(pend_c), exp_pend(2));
    check("sat_chg",   32'(chg_c),  exp_chg(2));
    check("sat_cnt",   32'(cnt_c),  32'(mcnt[2]));
  endtask

  task automatic step(input logic r, input logic [N-1:0] l, input logic [N*W-1:0] lv,
                      input logic [N-1:0] e, input logic [N*W-1:0] dd, input logic cm);
    rst = r; ld = l; lval = lv; en = e; d = dd; commit = cm;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; ld = '0; lval = '0; en = '0; d = '0; commit = 1'b0;

    // Reset state.
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 0);
    check("rst_q_imm", 32'(q_a), 32'h0000_0000);
    check("rst_q_sat", 32'(q_c), 32'hC3C3_C3C3);
    check("rst_cnt_imm", 32'(cnt_a), 32'd0);

    // Immediate load on ch0 and ch2.
    step(0, 4'b0101, 32'h003C_00A5, 4'b0000, 32'h0, 0);
    check("imm_ld_q", 32'(q_a), 32'h003C_00A5);
    check("imm_ld_chg", 32'(chg_a), 32'h5);
    check("imm_ld_cnt", 32'(cnt_a), 32'd2);

    // Deferred: stage twice, en in between, then commit.
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 0);
    step(0, 4'b0010, 32'h0000_1100, 4'b0000, 32'h0, 0);
    check("def_s1_q", 32'(q_b[15:8]), 32'h00);
    check("def_s1_pend", 32'(pend_b[1]), 32'd1);
    step(0, 4'b0010, 32'h0000_2200, 4'b0000, 32'h0, 0);
    check("def_s2_q", 32'(q_b[15:8]), 32'h00);
    step(0, 4'b0000, 32'h0, 4'b0010, 32'h0000_7700, 0);
    check("def_s3_q", 32'(q_b[15:8]), 32'h77);
    check("def_s3_pend", 32'(pend_b[1]), 32'd1);
    step(0, 4'b0000, 32'h0, 4'b0000, 32'h0, 1);
    check("def_s4_q", 32'(q_b[15:8]), 32'h22);
    check("def_s4_pend", 32'(pend_b[1]), 32'd0);
    check("def_s4_cnt", 32'(cnt_b), 32'd1);

    // Deferred bypass: load with commit.
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 0);
    step(0, 4'b1000, 32'h5A00_0000, 4'b0000, 32'h0, 1);
    check("byp_q", 32'(q_b[31:24]), 32'h5A);
    check("byp_pend", 32'(pend_b[3]), 32'd0);

    // Counter saturation with a 2-bit counter.
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0001, $urandom, 4'b0000, 32'h0, 0);
      check("sat_seq", 32'(cnt_c), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Reset discards staged loads, even with commit asserted.
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 0);
    step(0, 4'b0101, 32'h0099_0066, 4'b0000, 32'h0, 0);
    step(1, 4'b0000, 32'h0, 4'b0000, 32'h0, 1);
    check("rstp_q", 32'(q_b), 32'h0);
    check("rstp_pend", 32'(pend_b), 32'h0);
    check("rstp_chg", 32'(chg_b), 32'h0);
    step(0, 4'b0000, 32'h0, 4'b0000, 32'h0, 1);
    check("rstp_cmt_q", 32'(q_b), 32'h0);
    check("rstp_cmt_cnt", 32'(cnt_b), 32'd0);

    // Reloading an equal value counts but does not flag a change.
    step(0, 4'b0001, 32'h0000_00A5, 4'b0000, 32'h0, 0);
    step(0, 4'b0001, 32'h0000_00A5, 4'b0000, 32'h0, 0);
    check("eq_chg", 32'(chg_a[0]), 32'd0);
    check("eq_cnt", 32'(cnt_a), 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(63) == 0, 4'($urandom), $urandom, 4'($urandom), $urandom,
           $urandom_range(3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldreg_bank.md
LDREG_BANK -- requirements
Module: ldreg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, number of channels.
REQ-003 SHALL have parameter RST_VAL, WIDTH bits, default 0, reset value of every channel.
REQ-004 SHALL have parameter LD_MODE, ldreg_pkg::ld_mode_e, default LD_IMM, with values LD_IMM (load applies directly) and LD_DEFER (load staged until commit).
REQ-005 SHALL have parameter CW, default 8, load-counter width.
REQ-006 Ports, in this order:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous reset, active-high
- d_i  input  NCH*WIDTH  per-channel data
- en_i  input  NCH  per-channel clock enable
- ld_i  input  NCH  per-channel load request
- lval_i  input  NCH*WIDTH  per-channel load value
- commit_i  input  1  global commit (LD_DEFER only, ignored in LD_IMM)
- q_o  output  NCH*WIDTH  channel registers
- pend_o  output  NCH  staged load pending (always 0 in LD_IMM)
- chg_o  output  NCH  q changed on previous edge
- ldcnt_o  output  CW  count of applied loads, saturating
REQ-007 Channel c SHALL occupy bits [c*WIDTH +: WIDTH] of every packed vector.

Function
REQ-008 Per-channel priority at each clk edge SHALL be: rst > applied load > en_i > hold.
REQ-009 LD_IMM: ld_i[c]=1 SHALL set q[c] to lval_i[c] at that edge, with 1-cycle latency, regardless of en_i[c].
REQ-010 LD_DEFER: ld_i[c]=1 without commit_i SHALL capture lval_i[c] into stage[c] and set pend[c]; q[c] SHALL be unaffected by the load.
REQ-011 LD_DEFER: ld_i[c]=1 while pend[c]=1 SHALL overwrite stage[c] (last write wins).
REQ-012 LD_DEFER: commit_i=1 SHALL copy stage[c] into q[c] and clear pend[c] for every pending channel simultaneously.
REQ-013 LD_DEFER: ld_i[c]=1 and commit_i=1 in the same cycle SHALL bypass: q[c] takes lval_i[c] and pend[c] is cleared.
REQ-014 LD_DEFER: commit_i=1 with no pending and no ld SHALL leave the channel to en_i/hold and count nothing.
REQ-015 en_i[c]=1 on a pending channel without commit SHALL load d_i[c] into q[c] and leave pend[c] and stage[c] intact.
REQ-016 chg_o[c] SHALL be registered and equal 1 for exactly the cycle after an edge at which q[c] took a different value (a load of an equal value gives chg_o=0).
REQ-017 ldcnt_o SHALL increase by the number of channels whose load was applied at that edge (LD_IMM: ld_i; LD_DEFER: commit or bypass), saturating at 2^CW-1 with no wrap.
REQ-018 The per-edge ldcnt_o increment SHALL be computed at width clog2(NCH+1)+CW so that the saturation compare cannot overflow.

Reset
REQ-019 rst=1 SHALL set q_o=RST_VAL for all channels, pend_o=0, stage=RST_VAL, chg_o=0 and ldcnt_o=0 at the next edge, overriding ld_i, en_i and commit_i.
REQ-020 rst asserted while loads are pending SHALL discard them; no commit SHALL apply after reset.
REQ-021 The reset-induced change of q SHALL NOT set chg_o.

Structure
REQ-022 ld_mode_e and the LD_IMM/LD_DEFER enumerators SHALL live in shared package ldreg_pkg.
REQ-023 The per-channel register, stage, pend and chg logic SHALL be one sub-module, ldreg_ch, instantiated NCH times via generate.
REQ-024 The top level SHALL contain only the generate loop and the saturating ldcnt_o adder.
REQ-025 The block SHALL contain no latches, no asynchronous logic and no clock gating.

Verification
REQ-026 LD_IMM, WIDTH=8, NCH=4: reset, then ld_i=4'b0101 with lval ch0=0xA5 and ch2=0x3C -> next cycle q ch0=0xA5, ch2=0x3C, ch1=ch3=0x00; chg_o=4'b0101; ldcnt_o=2.
REQ-027 LD_DEFER: ld ch1=0x11, then ld ch1=0x22, then en ch1 with d=0x77, then commit -> q ch1 reads 0x00, 0x00, 0x77, then 0x22; pend_o[1] 1 until commit, then 0; ldcnt_o=1.
REQ-028 LD_DEFER: ld ch3=0x5A together with commit_i=1 -> q ch3=0x5A next cycle; pend_o[3] never 1.
REQ-029 CW=2, LD_IMM: apply 5 single-channel loads -> ldcnt_o sequence 1,2,3,3,3.
REQ-030 LD_DEFER: stage ch0 and ch2, assert rst and commit_i together -> q=RST_VAL, pend_o=0, chg_o=0; commit on the next cycle changes nothing.
REQ-031 ld ch0 with lval equal to the current q -> chg_o[0]=0 and ldcnt_o still increments.
